// File: rtl/multi_port_main_memory_pkg.sv
// Shared types for the multi-port main memory: FSM states, per-beat access sizes,
// latched request control and the size decode.
package multi_port_main_memory_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_XFER = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  localparam logic [2:0] ONE_BYTE  = 3'd0;
  localparam logic [2:0] TWO_BYTE  = 3'd1;
  localparam logic [2:0] FOUR_BYTE = 3'd2;

  typedef struct packed {
    logic       write;
    logic [2:0] rtype;
  } mem_ctrl_t;

  // Bytes moved per beat; 0 marks an invalid type, whose beats are skipped.
  function automatic logic [2:0] type_size(input logic [2:0] i_type);
    case (i_type)
      ONE_BYTE:  return 3'd1;
      TWO_BYTE:  return 3'd2;
      FOUR_BYTE: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/multi_port_main_memory_arbiter.sv
// Fixed-priority arbiter: one-hot grant to the lowest-index requester.
module multi_port_main_memory_arbiter #(
  parameter int unsigned NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_grant_c
);

  // Isolate the lowest set bit.
  assign o_grant_c = i_req & (~i_req + NUM_CH'(1));

endmodule

// File: rtl/multi_port_main_memory.sv
// Multi-channel byte-addressed main memory with fixed-priority arbitration,
// programmable access latency and big-endian multi-beat bursts.
module multi_port_main_memory
  import multi_port_main_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned LEN              = 32,
  parameter int unsigned BYTE_SIZE        = 8,
  parameter int unsigned NUM_CH           = 3,
  parameter int unsigned ENTRY_INDEX_SIZE = 3,
  parameter int unsigned LATENCY          = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     req_valid,
  input  logic [NUM_CH-1:0]                     req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]          req_addr,
  input  logic [NUM_CH*(ENTRY_INDEX_SIZE+1)-1:0] req_len,
  input  logic [NUM_CH*3-1:0]                   req_type,
  input  logic [NUM_CH*LEN-1:0]                 req_wdata,
  output logic [NUM_CH-1:0]                     beat_ack,
  output logic [LEN-1:0]                        rdata,
  output logic [NUM_CH-1:0]                     rdata_vld,
  output logic [NUM_CH-1:0]                     done,
  output logic                                  busy
);

  localparam int unsigned BUS_BYTES = LEN / BYTE_SIZE;
  localparam int unsigned LW        = ENTRY_INDEX_SIZE + 1;
  localparam int unsigned CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  mem_state_e                r_state;
  mem_state_e                w_next_state;
  logic [NUM_CH-1:0]         r_grant;
  mem_ctrl_t                 r_ctrl;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [LW-1:0]             r_len;
  logic [LW-1:0]             r_beat_cnt;
  logic [CW-1:0]             r_lat_cnt;
  logic [NUM_CH-1:0]         r_beat_ack;
  logic [LEN-1:0]            r_rdata;
  logic [NUM_CH-1:0]         r_rdata_vld;
  logic [NUM_CH-1:0]         r_done;
  logic                      r_busy;
  logic [BYTE_SIZE-1:0]      r_mem [DEPTH];

  logic [NUM_CH-1:0]         w_grant_c;
  logic [ADDR_WIDTH-1:0]     w_sel_addr;
  logic [LW-1:0]             w_sel_len;
  mem_ctrl_t                 w_sel_ctrl;
  logic [LEN-1:0]            w_wr_beat;
  logic [LEN-1:0]            w_rd_beat;
  logic [2:0]                w_size;
  logic                      w_last;
  logic [NUM_CH-1:0]         w_beat_ack_nxt;
  logic [NUM_CH-1:0]         w_done_nxt;
  logic                      w_busy_nxt;
  logic [ADDR_WIDTH-1:0]     w_lane_addr [BUS_BYTES];

  multi_port_main_memory_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_req     (req_valid),
    .o_grant_c (w_grant_c)
  );

  // Mux the granted channel's request fields (new grant) and write data (held grant).
  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_ctrl = '0;
    w_wr_beat  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant_c[i]) begin
        w_sel_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len        = req_len[i*LW +: LW];
        w_sel_ctrl.write = req_write[i];
        w_sel_ctrl.rtype = req_type[i*3 +: 3];
      end
      if (r_grant[i]) begin
        w_wr_beat = req_wdata[i*LEN +: LEN];
      end
    end
  end

  // Byte lanes: lane 0 is the beat MSB; lane addresses wrap at the top of storage.
  always_comb begin
    w_size    = type_size(r_ctrl.rtype);
    w_rd_beat = '0;
    for (int unsigned b = 0; b < BUS_BYTES; b++) begin
      w_lane_addr[b] = r_addr + ADDR_WIDTH'(b);
      if (b < 32'(w_size)) begin
        w_rd_beat[(BUS_BYTES-1-b)*BYTE_SIZE +: BYTE_SIZE] = r_mem[w_lane_addr[b]];
      end
    end
  end

  assign w_last = (r_beat_cnt == r_len - LW'(1));

  always_comb begin
    w_next_state   = r_state;
    w_beat_ack_nxt = '0;
    w_done_nxt     = '0;
    case (r_state)
      MEM_IDLE: if (|req_valid) w_next_state = (LATENCY == 1) ? MEM_XFER : MEM_WAIT;
      MEM_WAIT: if (r_lat_cnt == CW'(1)) w_next_state = MEM_XFER;
      MEM_XFER: if (w_last) w_next_state = MEM_DONE;
      MEM_DONE: w_next_state = MEM_IDLE;
      default:  w_next_state = MEM_IDLE;
    endcase
    // A direct IDLE->XFER hop has not latched the grant yet.
    if (w_next_state == MEM_XFER) begin
      w_beat_ack_nxt = (r_state == MEM_IDLE) ? w_grant_c : r_grant;
    end
    if (w_next_state == MEM_DONE) begin
      w_done_nxt = r_grant;
    end
    w_busy_nxt = (w_next_state != MEM_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MEM_IDLE;
      r_grant     <= '0;
      r_ctrl      <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_beat_ack  <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_beat_ack  <= w_beat_ack_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_rdata_vld <= '0;
      case (r_state)
        MEM_IDLE: begin
          if (|req_valid) begin
            r_grant    <= w_grant_c;
            r_ctrl     <= w_sel_ctrl;
            r_addr     <= w_sel_addr;
            r_len      <= (w_sel_len == '0) ? LW'(1) : w_sel_len;
            r_lat_cnt  <= CW'(LATENCY - 1);
            r_beat_cnt <= '0;
          end
        end
        MEM_WAIT: r_lat_cnt <= r_lat_cnt - CW'(1);
        MEM_XFER: begin
          r_addr     <= r_addr + ADDR_WIDTH'(w_size);
          r_beat_cnt <= r_beat_cnt + LW'(1);
          if (!r_ctrl.write && (w_size != 3'd0)) begin
            r_rdata     <= w_rd_beat;
            r_rdata_vld <= r_grant;
          end
        end
        MEM_DONE: ;
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if ((r_state == MEM_XFER) && r_ctrl.write) begin
      for (int unsigned b = 0; b < BUS_BYTES; b++) begin
        if (b < 32'(w_size)) begin
          r_mem[w_lane_addr[b]] <= w_wr_beat[(BUS_BYTES-1-b)*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  assign beat_ack  = r_beat_ack;
  assign rdata     = r_rdata;
  assign rdata_vld = r_rdata_vld;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule
